instruction_fetch: RTL
======================

Name: instruction_fetch

Overview:
IF stage plus IF/ID pipeline register for the 5-stage MIPS core. It sits directly upstream of the decode stage. It issues word fetches to instruction memory over a req/ack handshake and delivers pc/instr to decode. It applies decode's branch, jump and jr redirects with MIPS delay-slot semantics and holds or bubbles the ID register on decode stall or memory latency.

Parameters:
RESET_PC, 32'h0000_0000, address of the first fetch after reset (word-aligned).

Ports:
clk  input  1  core clock
rst  input  1  synchronous reset, active-high
imem_req  output  1  fetch request, held until imem_ack
imem_addr  output  32  fetch byte address, word-aligned, stable while imem_req=1
imem_ack  input  1  one-cycle pulse; imem_rdata valid this cycle; may coincide with the first req cycle
imem_rdata  input  32  fetched instruction word
stall  input  1  decode stall; hold the ID register
jump_branch  input  1  branch in ID taken
jump_target  input  1  J in ID
jump_reg  input  1  JR in ID
jr_pc  input  32  JR target (forwarded rs)
pc_id  output  32  PC of the instruction in ID
instr_id  output  32  instruction in ID; 32'h0 (NOP) when bubble
valid_id  output  1  instr_id is a real fetched instruction

Behaviour:
- Single clock, rst synchronous active-high. All state updates on posedge clk.
- Reset values: pc_id=RESET_PC, instr_id=0, valid_id=0, imem_req=0, fetch_pc=RESET_PC, redirect_pending=0, skid empty, state=IDLE.
- One outstanding request max.
- FSM states:
  - IDLE: imem_req=0; unconditionally goes to REQ next cycle; imem_ack ignored.
  - REQ: imem_req=1, imem_addr=fetch_pc. On imem_ack:
    - If ID can accept (valid_id=0 or stall=0): ID <= {fetch_pc, imem_rdata, valid=1}; stay in REQ.
    - Otherwise: skid <= {fetch_pc, imem_rdata}; go to HOLD.
    - In both cases fetch_pc <= next_fetch.
  - HOLD: imem_req=0. When stall=0, ID <= skid, skid emptied, go to REQ.
- ID register update:
  - stall=1 and valid_id=1: hold pc_id, instr_id and valid_id.
  - ID advancing with nothing to load: instr_id <= 0, valid_id <= 0, pc_id unchanged.
- next_fetch = redirect_pending ? redirect_pc : fetch_pc+4. redirect_pending is cleared when it is consumed.
- Redirect is accepted only when valid_id=1 and stall=0. Redirect signals are ignored while stall=1.
- Target selection priority: jump_reg > jump_target > jump_branch.
  - jr: jr_pc.
  - j: {pc_id[31:28]+carry of pc_id+4, instr_id[25:0], 2'b00}, i.e. upper 4 bits taken from pc_id+4.
  - branch: pc_id + 4 + {{14{instr_id[15]}}, instr_id[15:0], 2'b00}.
  - All arithmetic is mod 2^32.
- Delay slot: the instruction at pc_id+4 always enters ID. When branch B is in ID, fetch_pc is already B+4.
  - Case a, REQ with no ack this cycle: redirect_pc <= target, redirect_pending <= 1. The B+4 request completes, and its ack sets fetch_pc <= target.
  - Case b, ack this cycle or state HOLD: fetch_pc <= target directly, overriding the +4 update. The B+8 address is never requested.
- Bits [1:0] of targets are not checked. Target fetch is issued as-is with addr[1:0] forced to 0.
- Mid-operation reset: an in-flight request is abandoned, and an ack arriving in IDLE is dropped. The first request after reset is RESET_PC, two cycles after rst deasserts (IDLE then REQ).
- Simultaneous ack and stall=1 with valid_id=1: data goes to the skid buffer and is never lost.
- Skid-to-ID and a new ack can never collide, because HOLD issues no request.

Optional Feature:
IFETCH_PERF_EN
- Defined: adds two outputs, reset to 0, each wrapping at 2^32:
  - fetch_count (32): increments on every imem_ack accepted in REQ.
  - bubble_count (32): increments on every cycle the ID register loads a bubble.
- Undefined: these ports and counters are absent. All other behaviour is identical.

Test Plan:
- Reset, memory acks every cycle, stall=0 -> addresses 0x0,0x4,0x8… on consecutive accepted fetches; first valid_id=1 with pc_id=0.
- BEQ at 0x10 with imm=0x0003, jump_branch=1, ack in same cycle as the branch is in ID -> ID sequence 0x10, 0x14 (delay slot), 0x20. Address 0x18 is never requested.
- J at 0x100 with target field 0x0000040, ack for 0x104 delayed 3 cycles -> redirect_pending set. After 0x104 acks, next imem_addr=0x100 and ID shows 0x104 then 0x100.
- stall=1 for 4 cycles while ack for 0x8 arrives -> state HOLD, imem_req=0, pc_id=0x4 held. After stall drops, ID=0x8 next cycle and a request for 0xC follows.
- jump_reg=1 with jr_pc=0x400 while stall=1, then stall=0 with jr_pc=0x500 -> only 0x500 is used. Memory latency 2 cycles -> bubbles with instr_id=0 and valid_id=0 between valid instructions.
- rst asserted while a request for 0x40 is pending, ack arrives during IDLE -> ack ignored and the next request is RESET_PC. With IFETCH_PERF_EN, counters read 0 after reset.

Source files
------------

// File: rtl/instruction_fetch.sv
// IF stage plus IF/ID pipeline register for the 5-stage MIPS core, with delay-slot redirects.
// Define IFETCH_PERF_EN to add the fetch_count / bubble_count performance counters.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        jump_branch,
    input  logic        jump_target,
    input  logic        jump_reg,
    input  logic [31:0] jr_pc,
    output logic [31:0] pc_id,
    output logic [31:0] instr_id,
    output logic        valid_id
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] bubble_count
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD} state_t;

    state_t      r_state;
    logic        r_imem_req;
    logic [31:0] r_fetch_pc;
    logic        r_redirect_pending;
    logic [31:0] r_redirect_pc;
    logic [31:0] r_skid_pc;
    logic [31:0] r_skid_instr;
    logic [31:0] r_pc_id;
    logic [31:0] r_instr_id;
    logic        r_valid_id;

    logic        w_id_accept;
    logic        w_redirect;
    logic        w_ack;
    logic        w_load_fetch;
    logic        w_load_skid;
    logic        w_bubble;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_branch_off;
    logic [31:0] w_target_raw;
    logic [31:0] w_target;
    logic [31:0] w_next_fetch;

    assign w_id_accept  = ~r_valid_id | ~stall;
    assign w_redirect   = r_valid_id & ~stall & (jump_reg | jump_target | jump_branch);
    assign w_ack        = (r_state == S_REQ) & imem_ack;
    assign w_load_fetch = w_ack & w_id_accept;
    assign w_load_skid  = (r_state == S_HOLD) & ~stall;
    // HOLD always has a skid entry to hand over, so it never produces a bubble.
    assign w_bubble     = w_id_accept & ~w_ack & (r_state != S_HOLD);

    assign w_pc_plus4   = r_pc_id + 32'd4;
    assign w_branch_off = {{14{r_instr_id[15]}}, r_instr_id[15:0], 2'b00};
    assign w_next_fetch = r_redirect_pending ? r_redirect_pc : (r_fetch_pc + 32'd4);
    assign w_target     = w_target_raw & ~32'h0000_0003;

    // NOTE: the default assignment first covers every path, so no latch is inferred.
    always_comb begin
        w_target_raw = w_pc_plus4 + w_branch_off;
        if (jump_reg) begin
            w_target_raw = jr_pc;
        end else if (jump_target) begin
            w_target_raw = {w_pc_plus4[31:28], r_instr_id[25:0], 2'b00};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state            <= S_IDLE;
            r_imem_req         <= 1'b0;
            r_fetch_pc         <= RESET_PC;
            r_redirect_pending <= 1'b0;
            r_redirect_pc      <= RESET_PC;
            r_skid_pc          <= RESET_PC;
            r_skid_instr       <= 32'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state    <= S_REQ;
                    r_imem_req <= 1'b1;
                end
                S_REQ: begin
                    if (imem_ack) begin
                        // A redirect seen together with the delay-slot ack skips B+8 entirely.
                        r_fetch_pc         <= w_redirect ? w_target : w_next_fetch;
                        r_redirect_pending <= 1'b0;
                        if (!w_id_accept) begin
                            r_skid_pc    <= r_fetch_pc;
                            r_skid_instr <= imem_rdata;
                            r_state      <= S_HOLD;
                            r_imem_req   <= 1'b0;
                        end
                    end else if (w_redirect) begin
                        r_redirect_pc      <= w_target;
                        r_redirect_pending <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (w_redirect) begin
                        r_fetch_pc <= w_target;
                    end
                    if (!stall) begin
                        r_state    <= S_REQ;
                        r_imem_req <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_imem_req <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc_id    <= RESET_PC;
            r_instr_id <= 32'h0;
            r_valid_id <= 1'b0;
        end else if (w_load_fetch) begin
            r_pc_id    <= r_fetch_pc;
            r_instr_id <= imem_rdata;
            r_valid_id <= 1'b1;
        end else if (w_load_skid) begin
            r_pc_id    <= r_skid_pc;
            r_instr_id <= r_skid_instr;
            r_valid_id <= 1'b1;
        end else if (w_bubble) begin
            r_instr_id <= 32'h0;
            r_valid_id <= 1'b0;
        end
    end

`ifdef IFETCH_PERF_EN
    logic [31:0] r_fetch_count;
    logic [31:0] r_bubble_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_count  <= 32'h0;
            r_bubble_count <= 32'h0;
        end else begin
            if (w_ack)    r_fetch_count  <= r_fetch_count + 32'd1;
            if (w_bubble) r_bubble_count <= r_bubble_count + 32'd1;
        end
    end

    assign fetch_count  = r_fetch_count;
    assign bubble_count = r_bubble_count;
`endif

    assign imem_req  = r_imem_req;
    assign imem_addr = r_fetch_pc;
    assign pc_id     = r_pc_id;
    assign instr_id  = r_instr_id;
    assign valid_id  = r_valid_id;

endmodule
